// File: rtl/mc_axil_csr_master_bridge_if.sv
// mc_axil_csr_master_bridge_if: AXI4-Lite bus bundle, used for both the CSR slave port and the master port.
interface mc_axil_csr_master_bridge_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [addr_width_p-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mc_axil_csr_master_bridge.sv
// mc_axil_csr_master_bridge: CSR-programmed single-shot AXI-Lite master; define MC_BRIDGE_TIMEOUT_EN for the response timeout/drain logic.
module mc_axil_csr_master_bridge #(
  parameter int s_addr_width_p   = 6,
  parameter int m_addr_width_p   = 32,
  parameter int m_data_width_p   = 64,
  parameter int timeout_cycles_p = 1024
) (
  input logic                          clk_i,
  input logic                          reset_i,
  mc_axil_csr_master_bridge_if.slave   s00_axi,
  mc_axil_csr_master_bridge_if.master  m01_axi
);
  localparam int nw = m_data_width_p / 32;
  localparam int sw = m_data_width_p / 8;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_e;
  state_e state_r, state_n;
  logic [31:0] addr_r;
  logic [sw-1:0] wstrb_r, m_wstrb_r;
  logic [nw-1:0][31:0] wdata_r, rdata_r;
  logic done_r, timeout_r, overrun_r;
  logic [1:0] resp_r;
  logic [15:0] count_r;
  logic [m_addr_width_p-1:0] m_addr_r;
  logic [m_data_width_p-1:0] m_wdata_r;
  logic aw_pend, w_pend, ar_pend, drain_wr, drain_rd, to_hit, tmo;
  logic s_bvalid_r, s_rvalid_r;
  logic [1:0] s_bresp_r, s_rresp_r;
  logic [31:0] s_rdata_r, rd_mux, status;
  logic wr_en, rd_en, go, go_ok, busy;
  int wi, ri;
  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] st);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b+:8] = st[b] ? n[8*b+:8] : o[8*b+:8];
    return r;
  endfunction
  function automatic logic mapped(input int i);
    return i < 4 + nw || (i >= 8 && i < 8 + nw);
  endfunction
  assign wi = int'(s00_axi.awaddr[s_addr_width_p-1:2]);
  assign ri = int'(s00_axi.araddr[s_addr_width_p-1:2]);
  assign wr_en = s00_axi.awvalid && s00_axi.wvalid && !s_bvalid_r;
  assign rd_en = s00_axi.arvalid && !s_rvalid_r;
  assign busy = state_r != IDLE;
  assign go_ok = !busy && !drain_wr && !drain_rd;
  assign go = wr_en && wi == 1 && s00_axi.wstrb[0] && s00_axi.wdata[0];
  assign status = {count_r, 10'b0, overrun_r, timeout_r, resp_r, done_r, busy};
  assign s00_axi.awready = wr_en;
  assign s00_axi.wready = wr_en;
  assign s00_axi.bvalid = s_bvalid_r;
  assign s00_axi.bresp = s_bresp_r;
  assign s00_axi.arready = rd_en;
  assign s00_axi.rvalid = s_rvalid_r;
  assign s00_axi.rdata = s_rdata_r;
  assign s00_axi.rresp = s_rresp_r;
  assign m01_axi.awaddr = m_addr_r;
  assign m01_axi.awprot = 3'b000;
  assign m01_axi.awvalid = aw_pend;
  assign m01_axi.wdata = m_wdata_r;
  assign m01_axi.wstrb = m_wstrb_r;
  assign m01_axi.wvalid = w_pend;
  assign m01_axi.bready = state_r == WR_RESP || drain_wr;
  assign m01_axi.araddr = m_addr_r;
  assign m01_axi.arprot = 3'b000;
  assign m01_axi.arvalid = ar_pend;
  assign m01_axi.rready = state_r == RD_DATA || drain_rd;
  logic unused_ok;
  assign unused_ok = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0], s00_axi.awprot, s00_axi.arprot, timeout_cycles_p != 0};
  always_comb begin
    rd_mux = '0;
    if (ri == 0) rd_mux = addr_r;
    if (ri == 2) rd_mux = status;
    if (ri == 3) rd_mux = 32'(wstrb_r);
    for (int k = 0; k < nw; k++) begin
      if (ri == 4 + k) rd_mux = wdata_r[k];
      if (ri == 8 + k) rd_mux = rdata_r[k];
    end
  end
  always_comb begin
    state_n = state_r;
    tmo = 1'b0;
    case (state_r)
      IDLE:    state_n = go && go_ok ? (s00_axi.wdata[1] ? RD_REQ : WR_REQ) : IDLE;
      WR_REQ:  if ((!aw_pend || m01_axi.awready) && (!w_pend || m01_axi.wready)) state_n = WR_RESP; else tmo = to_hit;
      WR_RESP: if (m01_axi.bvalid) state_n = DONE; else tmo = to_hit;
      RD_REQ:  if (m01_axi.arready) state_n = RD_DATA; else tmo = to_hit;
      RD_DATA: if (m01_axi.rvalid) state_n = DONE; else tmo = to_hit;
      default: state_n = IDLE;
    endcase
    if (tmo) state_n = DONE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      {aw_pend, w_pend, ar_pend} <= '0;
      m_addr_r <= '0;
      m_wdata_r <= '0;
      m_wstrb_r <= '0;
    end else begin
      state_r <= state_n;
      if (go && go_ok) begin
        aw_pend <= !s00_axi.wdata[1];
        w_pend <= !s00_axi.wdata[1];
        ar_pend <= s00_axi.wdata[1];
        m_addr_r <= m_addr_width_p'(addr_r);
        m_wdata_r <= wdata_r;
        m_wstrb_r <= wstrb_r;
      end else begin
        aw_pend <= aw_pend && !m01_axi.awready;
        w_pend <= w_pend && !m01_axi.wready;
        ar_pend <= ar_pend && !m01_axi.arready;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_r <= '0;
      wstrb_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      {done_r, timeout_r, overrun_r, resp_r, count_r} <= '0;
      {s_bvalid_r, s_rvalid_r, s_bresp_r, s_rresp_r, s_rdata_r} <= '0;
    end else begin
      if (wr_en) begin
        if (wi == 0) addr_r <= byte_merge(addr_r, s00_axi.wdata, s00_axi.wstrb);
        if (wi == 3) wstrb_r <= sw'(byte_merge(32'(wstrb_r), s00_axi.wdata, s00_axi.wstrb));
        for (int k = 0; k < nw; k++)
          if (wi == 4 + k) wdata_r[k] <= byte_merge(wdata_r[k], s00_axi.wdata, s00_axi.wstrb);
        if (wi == 2 && s00_axi.wstrb[0]) begin
          if (s00_axi.wdata[1]) done_r <= 1'b0;
          if (s00_axi.wdata[4]) timeout_r <= 1'b0;
          if (s00_axi.wdata[5]) overrun_r <= 1'b0;
        end
      end
      // sticky sets come after the write-1-clears so a coincident event wins
      if (go && !go_ok) overrun_r <= 1'b1;
      if (state_r == WR_RESP && m01_axi.bvalid) resp_r <= m01_axi.bresp;
      if (state_r == RD_DATA && m01_axi.rvalid) begin
        resp_r <= m01_axi.rresp;
        rdata_r <= m01_axi.rdata;
      end
      if (tmo) begin
        resp_r <= 2'b11;
        timeout_r <= 1'b1;
      end
      if (state_r == DONE) begin
        done_r <= 1'b1;
        count_r <= count_r + 16'd1;
      end
      if (wr_en) begin
        s_bvalid_r <= 1'b1;
        s_bresp_r <= mapped(wi) ? 2'b00 : 2'b10;
      end else if (s00_axi.bready) s_bvalid_r <= 1'b0;
      if (rd_en) begin
        s_rvalid_r <= 1'b1;
        s_rdata_r <= mapped(ri) ? rd_mux : '0;
        s_rresp_r <= mapped(ri) ? 2'b00 : 2'b10;
      end else if (s00_axi.rready) s_rvalid_r <= 1'b0;
    end
  end
`ifdef MC_BRIDGE_TIMEOUT_EN
  localparam int tw = $clog2(timeout_cycles_p + 1);
  logic [tw-1:0] to_cnt;
  assign to_hit = to_cnt == tw'(timeout_cycles_p - 1);
  always_ff @(posedge clk_i) begin
    if (reset_i || state_n != state_r) to_cnt <= '0;
    else if (state_r inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) to_cnt <= to_cnt + 1'b1;
  end
  // after a timeout, keep ready high until the abandoned response turns up
  always_ff @(posedge clk_i) begin
    if (reset_i) {drain_wr, drain_rd} <= '0;
    else if (tmo) begin
      drain_wr <= state_r inside {WR_REQ, WR_RESP};
      drain_rd <= state_r inside {RD_REQ, RD_DATA};
    end else begin
      if (m01_axi.bvalid && m01_axi.bready) drain_wr <= 1'b0;
      if (m01_axi.rvalid && m01_axi.rready) drain_rd <= 1'b0;
    end
  end
`else
  assign to_hit = 1'b0;
  assign drain_wr = 1'b0;
  assign drain_rd = 1'b0;
`endif
endmodule
